// File: rtl/bin2bcd_stream.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per cycle), optional signed input.
// Latency: operand accepted at edge k gives o_out_valid=1 after edge k+IN_WIDTH; one result per IN_WIDTH+1 cycles sustained.
// Backpressure: result held in DONE until i_out_ready; o_in_ready=1 in IDLE, follows i_out_ready in DONE, 0 while converting.
module bin2bcd_stream #(
    parameter int IN_WIDTH    = 32,
    parameter int DIGITS      = 10,
    parameter int SIGNED_MODE = 0
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    input  logic [IN_WIDTH-1:0]   i_in_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [4*DIGITS-1:0]   o_out_bcd,
    output logic                  o_out_sign,
    output logic                  o_out_ovf,
    output logic [DIGITS-1:0]     o_out_digit_en
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_WIDTH + 1);
    localparam logic [CW-1:0] LAST_STEP = CW'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [IN_WIDTH-1:0]   r_shift;
    logic [BW-1:0]         r_bcd;
    logic                  r_sign;
    logic                  r_ovf;

    logic [BW-1:0]         r_out_bcd;
    logic                  r_out_sign;
    logic                  r_out_ovf;
    logic [DIGITS-1:0]     r_out_digit_en;

    logic                  w_accept;
    logic                  w_last;
    logic                  w_neg;
    logic [IN_WIDTH-1:0]   w_mag;
    logic [BW-1:0]         w_adj;
    logic [BW-1:0]         w_bcd_nxt;
    logic [IN_WIDTH-1:0]   w_shift_nxt;
    logic                  w_ovf_nxt;
    logic [DIGITS-1:0]     w_digit_nz;
    logic [DIGITS-1:0]     w_digit_en;
    logic                  w_zero;

    // State register; an aborted conversion simply restarts from IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the unused encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_in_valid) begin
                    w_state_nxt = S_CONV;
                end
            end
            S_CONV: begin
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_out_ready) begin
                    w_state_nxt = i_in_valid ? S_CONV : S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake outputs; in_ready is gated by reset so nothing is accepted while held in reset.
    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_in_ready = i_rst_n;
            end
            S_DONE: begin
                o_in_ready  = i_rst_n & i_out_ready;
                o_out_valid = 1'b1;
            end
            default: begin
                o_in_ready  = 1'b0;
                o_out_valid = 1'b0;
            end
        endcase
    end

    assign w_accept = i_in_valid & o_in_ready;
    assign w_last   = (r_state == S_CONV) && (r_cnt == LAST_STEP);

    // Magnitude of the operand; the most negative value maps to 2^(IN_WIDTH-1) as unsigned.
    assign w_neg = (SIGNED_MODE != 0) && i_in_data[IN_WIDTH-1];
    assign w_mag = w_neg ? (-i_in_data) : i_in_data;

    // Add-3 correction on every digit that would reach 10 or more after doubling.
    always_comb begin
        w_adj = r_bcd;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_bcd[4*d +: 4] >= 4'd5) begin
                w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // Shift the corrected digits and binary operand left together; the bit leaving the top
    // digit means the value has outgrown the available digits.
    assign w_bcd_nxt   = {w_adj[BW-2:0], r_shift[IN_WIDTH-1]};
    assign w_shift_nxt = {r_shift[IN_WIDTH-2:0], 1'b0};
    assign w_ovf_nxt   = r_ovf | w_adj[BW-1];

    // Digit-enable mask: every digit at or below the most significant nonzero one; units always on.
    always_comb begin
        logic seen;
        seen       = 1'b0;
        w_digit_nz = '0;
        w_digit_en = '0;
        for (int d = DIGITS - 1; d >= 0; d--) begin
            w_digit_nz[d] = |w_bcd_nxt[4*d +: 4];
            seen          = seen | w_digit_nz[d];
            w_digit_en[d] = seen;
        end
        w_digit_en[0] = 1'b1;
    end

    // A true zero never reports a sign; an overflowed value with zero low digits is not zero.
    assign w_zero = ~(|w_bcd_nxt) & ~w_ovf_nxt;

    // Working registers: load on accept, one shift-and-add-3 step per cycle while converting.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_shift <= '0;
            r_bcd   <= '0;
            r_sign  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_shift <= w_mag;
            r_bcd   <= '0;
            r_sign  <= w_neg;
            r_ovf   <= 1'b0;
        end else if (r_state == S_CONV) begin
            r_cnt   <= r_cnt + CW'(1);
            r_shift <= w_shift_nxt;
            r_bcd   <= w_bcd_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Result registers only change on the final conversion step, so they stay stable under backpressure.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_bcd      <= '0;
            r_out_sign     <= 1'b0;
            r_out_ovf      <= 1'b0;
            r_out_digit_en <= DIGITS'(1);
        end else if (w_last) begin
            r_out_bcd      <= w_bcd_nxt;
            r_out_sign     <= r_sign & ~w_zero;
            r_out_ovf      <= w_ovf_nxt;
            r_out_digit_en <= w_digit_en;
        end
    end

    assign o_out_bcd      = r_out_bcd;
    assign o_out_sign     = r_out_sign;
    assign o_out_ovf      = r_out_ovf;
    assign o_out_digit_en = r_out_digit_en;

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Bench for bin2bcd_stream: three unsigned 32-bit instances (10, 8, 4 digits) run in lockstep,
// plus a signed 8-bit/3-digit instance; results compared to an arithmetic decimal model.
// Directed corner cases first, then randomized operands, backpressure, back-to-back and reset abort.
module tb_bin2bcd_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Shared stimulus for the three unsigned instances
    logic        iv;
    logic [31:0] id;
    logic        ordy;

    logic        a_rdy, a_vld, a_sign, a_ovf;
    logic [39:0] a_bcd;
    logic [9:0]  a_en;
    logic        b_rdy, b_vld, b_sign, b_ovf;
    logic [31:0] b_bcd;
    logic [7:0]  b_en;
    logic        d_rdy, d_vld, d_sign, d_ovf;
    logic [15:0] d_bcd;
    logic [3:0]  d_en;

    // Signed instance
    logic        c_iv;
    logic [7:0]  c_id;
    logic        c_ordy;
    logic        c_rdy, c_vld, c_sign, c_ovf;
    logic [11:0] c_bcd;
    logic [2:0]  c_en;

    bin2bcd_stream #(.IN_WIDTH(32), .DIGITS(10), .SIGNED_MODE(0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv), .o_in_ready(a_rdy), .i_in_data(id),
        .o_out_valid(a_vld), .i_out_ready(ordy), .o_out_bcd(a_bcd), .o_out_sign(a_sign),
        .o_out_ovf(a_ovf), .o_out_digit_en(a_en));

    bin2bcd_stream #(.IN_WIDTH(32), .DIGITS(8), .SIGNED_MODE(0)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv), .o_in_ready(b_rdy), .i_in_data(id),
        .o_out_valid(b_vld), .i_out_ready(ordy), .o_out_bcd(b_bcd), .o_out_sign(b_sign),
        .o_out_ovf(b_ovf), .o_out_digit_en(b_en));

    bin2bcd_stream #(.IN_WIDTH(32), .DIGITS(4), .SIGNED_MODE(0)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(iv), .o_in_ready(d_rdy), .i_in_data(id),
        .o_out_valid(d_vld), .i_out_ready(ordy), .o_out_bcd(d_bcd), .o_out_sign(d_sign),
        .o_out_ovf(d_ovf), .o_out_digit_en(d_en));

    bin2bcd_stream #(.IN_WIDTH(8), .DIGITS(3), .SIGNED_MODE(1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(c_iv), .o_in_ready(c_rdy), .i_in_data(c_id),
        .o_out_valid(c_vld), .i_out_ready(c_ordy), .o_out_bcd(c_bcd), .o_out_sign(c_sign),
        .o_out_ovf(c_ovf), .o_out_digit_en(c_en));

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- decimal reference model ----------------
    function automatic logic [63:0] pow10(input int d);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < d; i++) r = r * 64'd10;
        return r;
    endfunction

    function automatic logic [63:0] m_bcd(input logic [63:0] m, input int d);
        logic [63:0] r;
        logic [63:0] v;
        r = 64'd0;
        v = m;
        for (int i = 0; i < d; i++) begin
            r = r | ((v % 64'd10) << (4 * i));
            v = v / 64'd10;
        end
        return r;
    endfunction

    function automatic logic [63:0] m_ovf(input logic [63:0] m, input int d);
        return (m >= pow10(d)) ? 64'd1 : 64'd0;
    endfunction

    function automatic logic [63:0] m_en(input logic [63:0] m, input int d);
        logic [63:0] v;
        int n;
        v = m % pow10(d);
        n = 0;
        while (v != 64'd0) begin
            n++;
            v = v / 64'd10;
        end
        if (n == 0) n = 1;
        return (64'd1 << n) - 64'd1;
    endfunction

    // ---------------- unsigned lockstep transaction ----------------
    task automatic run_u(input logic [31:0] v, input bit hold);
        int n;
        logic [63:0] m;
        m = {32'd0, v};
        @(negedge clk);
        iv   = 1'b1;
        id   = v;
        ordy = 1'b0;
        n = 0;
        while (!a_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("u_accept_rdy", 64'(a_rdy), 64'd1);
        @(posedge clk);
        #1 iv = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!a_vld && n < 200);
        chk_eq("u_latency", 64'(n), 64'd32);
        chk_eq("a_bcd",  64'(a_bcd),  m_bcd(m, 10));
        chk_eq("a_ovf",  64'(a_ovf),  m_ovf(m, 10));
        chk_eq("a_en",   64'(a_en),   m_en(m, 10));
        chk_eq("a_sign", 64'(a_sign), 64'd0);
        chk_eq("b_vld",  64'(b_vld),  64'd1);
        chk_eq("b_bcd",  64'(b_bcd),  m_bcd(m, 8));
        chk_eq("b_ovf",  64'(b_ovf),  m_ovf(m, 8));
        chk_eq("b_en",   64'(b_en),   m_en(m, 8));
        chk_eq("d_bcd",  64'(d_bcd),  m_bcd(m, 4));
        chk_eq("d_ovf",  64'(d_ovf),  m_ovf(m, 4));
        chk_eq("d_en",   64'(d_en),   m_en(m, 4));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk_eq("hold_vld", 64'(d_vld), 64'd1);
                chk_eq("hold_rdy", 64'(d_rdy), 64'd0);
                chk_eq("hold_bcd", 64'(d_bcd), m_bcd(m, 4));
                chk_eq("hold_en",  64'(d_en),  m_en(m, 4));
            end
        end
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        chk_eq("u_consumed_vld", 64'(a_vld), 64'd0);
    endtask

    // ---------------- signed transaction ----------------
    task automatic run_s(input logic [7:0] v);
        int n;
        logic [63:0] m;
        m = v[7] ? (64'd256 - {56'd0, v}) : {56'd0, v};
        @(negedge clk);
        c_iv   = 1'b1;
        c_id   = v;
        c_ordy = 1'b0;
        n = 0;
        while (!c_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk_eq("s_accept_rdy", 64'(c_rdy), 64'd1);
        @(posedge clk);
        #1 c_iv = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!c_vld && n < 100);
        chk_eq("s_latency", 64'(n), 64'd8);
        chk_eq("s_bcd",  64'(c_bcd),  m_bcd(m, 3));
        chk_eq("s_sign", 64'(c_sign), 64'(v[7]));
        chk_eq("s_ovf",  64'(c_ovf),  64'd0);
        chk_eq("s_en",   64'(c_en),   m_en(m, 3));
        @(negedge clk);
        c_ordy = 1'b1;
        @(posedge clk);
        #1 c_ordy = 1'b0;
    endtask

    initial begin
        logic [31:0] ops [3];
        int idx;
        int got;
        bit prev_vld;
        bit acc;
        logic [31:0] rv;

        rst_n = 1'b0;
        iv = 1'b0; id = '0; ordy = 1'b0;
        c_iv = 1'b0; c_id = '0; c_ordy = 1'b0;
        #13;
        chk_eq("rst_vld",  64'(a_vld),  64'd0);
        chk_eq("rst_rdy",  64'(a_rdy),  64'd0);
        chk_eq("rst_bcd",  64'(a_bcd),  64'd0);
        chk_eq("rst_en",   64'(a_en),   64'd1);
        chk_eq("rst_ovf",  64'(a_ovf),  64'd0);
        chk_eq("rst_sign", 64'(c_sign), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_eq("idle_rdy", 64'(a_rdy), 64'd1);

        // Directed unsigned corners
        run_u(32'hFFFF_FFFF, 1'b0);
        run_u(32'd99999999, 1'b0);
        run_u(32'd100000000, 1'b0);
        run_u(32'd305, 1'b1);
        run_u(32'd0, 1'b0);
        run_u(32'd9999, 1'b0);
        run_u(32'd10000, 1'b0);

        // Directed signed corners
        run_s(8'h80);
        run_s(8'hFF);
        run_s(8'h7F);
        run_s(8'h00);

        // Randomized operands
        for (int i = 0; i < 20; i++) begin
            case ($urandom_range(0, 2))
                0:       rv = $urandom;
                1:       rv = $urandom_range(0, 20000);
                default: rv = 32'd99999990 + $urandom_range(0, 20);
            endcase
            run_u(rv, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            rv = $urandom;
            run_s(rv[7:0]);
        end

        // Back-to-back: consume and accept on the same edge
        ops[0] = 32'd1; ops[1] = 32'd2; ops[2] = 32'd3;
        idx = 0; got = 0; prev_vld = 1'b0;
        @(negedge clk);
        ordy = 1'b1;
        for (int cyc = 0; cyc < 300 && got < 3; cyc++) begin
            @(negedge clk);
            if (idx < 3) begin
                iv = 1'b1;
                id = ops[idx];
            end else begin
                iv = 1'b0;
            end
            if (a_vld) begin
                chk_eq("bb_bcd", 64'(a_bcd), m_bcd({32'd0, ops[got]}, 10));
                chk_eq("bb_rdy", 64'(a_rdy), 64'd1);
                chk_eq("bb_one_cycle", 64'(prev_vld), 64'd0);
                got++;
            end
            prev_vld = a_vld;
            acc = iv && a_rdy;
            @(posedge clk);
            if (acc) idx++;
        end
        chk_eq("bb_count", 64'(got), 64'd3);
        #1;
        ordy = 1'b0;
        iv   = 1'b0;
        chk_eq("bb_end_vld", 64'(a_vld), 64'd0);

        // Reset in the middle of a conversion
        @(negedge clk);
        iv = 1'b1;
        id = 32'h1234_5678;
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_eq("abort_vld", 64'(a_vld), 64'd0);
        chk_eq("abort_rdy", 64'(a_rdy), 64'd0);
        chk_eq("abort_bcd", 64'(a_bcd), 64'd0);
        chk_eq("abort_en",  64'(a_en),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_u(32'd42, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
